// File: rtl/depth_test_buffer_pkg.sv
// Shared render types: depth word, farthest-depth constant and the depth-buffer FSM states.
package depth_test_buffer_pkg;
  localparam int DEPTH_W = 16;
  typedef logic [DEPTH_W-1:0] depth_t;
  localparam depth_t DEPTH_FAR = '1;
  typedef enum logic {IDLE, CLEAR} state_t;
endpackage

// File: rtl/depth_ram.sv
// Depth store: one synchronous write port, one synchronous read port.
// A same-address read and write on one edge returns the old word.
module depth_ram #(
  parameter int DW    = 16,
  parameter int AW    = 4,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/depth_test_buffer.sv
// Read-compare-write depth test for rasterizer fragments, 2-cycle latency, no backpressure.
// A clear command walks the store writing the farthest depth; fragments arriving meanwhile are dropped.
module depth_test_buffer
  import depth_test_buffer_pkg::*;
#(
  parameter int DEPTH_WIDTH   = 16,
  parameter int FB_ADDR_WIDTH = 4,
  parameter int FB_SIZE       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FB_ADDR_WIDTH-1:0] fb_addr,
  input  logic                     fb_write_enable,
  input  logic [DEPTH_WIDTH-1:0]   depth_data,
  input  logic                     clear_start,
  output logic                     pixel_write,
  output logic [FB_ADDR_WIDTH-1:0] pixel_addr,
  output logic [DEPTH_WIDTH-1:0]   pixel_depth,
  output logic                     busy,
  output logic                     clear_done,
  output logic                     frag_dropped
);
  localparam int AW = FB_ADDR_WIDTH;
  localparam int DW = DEPTH_WIDTH;
  localparam logic [AW:0]   SIZE = (AW+1)'(FB_SIZE);
  localparam logic [AW-1:0] LAST = AW'(FB_SIZE - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_cnt;
  logic            clr_last, clear_done_d;
  logic            addr_ok, accept, drop;
  logic            s1_vld;
  logic [AW-1:0]   s1_addr;
  logic [DW-1:0]   s1_depth;
  logic [DW-1:0]   rd_data, stored;
  logic            s1_pass;
  logic            ram_we;
  logic [AW-1:0]   ram_waddr;
  logic [DW-1:0]   ram_wdata;

  assign busy     = (state_q == CLEAR);
  assign clr_last = (clr_cnt == LAST);
  assign addr_ok  = ({1'b0, fb_addr} < SIZE);
  // An accepted clear_start takes priority over a fragment in the same cycle.
  assign accept   = fb_write_enable && (state_q == IDLE) && !clear_start && addr_ok;
  assign drop     = fb_write_enable && !accept;

  always_comb begin
    state_d      = state_q;
    clear_done_d = 1'b0;
    case (state_q)
      IDLE:  if (clear_start) state_d = CLEAR;
      CLEAR: if (clr_last) begin
        state_d      = IDLE;
        clear_done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // The pixel output registers double as the forwarding register: they hold the
  // word written on the same edge the next fragment's RAM read saw stale data.
  assign stored  = (pixel_write && (pixel_addr == s1_addr)) ? pixel_depth : rd_data;
  assign s1_pass = s1_vld && (s1_depth < stored);

  // Stage 1 is never valid while clearing, so the write port never collides.
  assign ram_we    = busy || s1_pass;
  assign ram_waddr = busy ? clr_cnt : s1_addr;
  assign ram_wdata = busy ? '1 : s1_depth;

  depth_ram #(.DW(DW), .AW(AW), .DEPTH(FB_SIZE)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (accept),
    .raddr (fb_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      clr_cnt      <= '0;
      clear_done   <= 1'b0;
      s1_vld       <= 1'b0;
      s1_addr      <= '0;
      s1_depth     <= '0;
      pixel_write  <= 1'b0;
      pixel_addr   <= '0;
      pixel_depth  <= '0;
      frag_dropped <= 1'b0;
    end else begin
      state_q    <= state_d;
      clear_done <= clear_done_d;
      if (busy) clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
      s1_vld <= accept;
      if (accept) begin
        s1_addr  <= fb_addr;
        s1_depth <= depth_data;
      end
      pixel_write <= s1_pass;
      if (s1_pass) begin
        pixel_addr  <= s1_addr;
        pixel_depth <= s1_depth;
      end
      if (drop) frag_dropped <= 1'b1;
    end
  end
endmodule
